// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 program loader: FSM state encoding,
// frame header byte and default inter-byte timeout.
package chip8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam logic [7:0] HEADER_BYTE            = 8'hA5;
  localparam int         LOADER_TIMEOUT_DEFAULT = 1000000;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/loader_timeout.sv
// Idle-cycle counter: expired_o flags the TIMEOUT-th consecutive enabled cycle
// without a clear, so a clear arriving in that same cycle can still win.
module loader_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/program_loader.sv
// Loads framed CHIP-8 program words (HEADER, N, 2N bytes, CHK) into instruction
// memory and keeps the CPU held until a frame passes its checksum.
//   state | meaning
//   IDLE  | waiting for HEADER after reset
//   LEN   | expecting word count N
//   HI    | expecting high byte of a word
//   LO    | expecting low byte; write issued the cycle after
//   CHK   | expecting checksum byte
//   DONE  | load good, CPU released
//   ERR   | load failed, CPU held
module program_loader
  import chip8_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter int         DATA_W  = 16,
  parameter logic [7:0] HEADER  = HEADER_BYTE,
  parameter int         TIMEOUT = LOADER_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  program_loader_if.master  bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);
  localparam int MAX_N = 1 << (ADDR_W - 1);

  if (DATA_W != 16) begin : g_bad_data_w
    $error("program_loader: DATA_W must be 16");
  end

  loader_state_e     state_q, state_d;
  logic              arm_q, in_ready_q;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        rem_q, rem_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept, len_ok, tmo_en, expired;

  assign accept = bus.in_valid && in_ready_q;
  assign len_ok = (bus.in_data != 8'd0) && (int'(bus.in_data) <= MAX_N);
  assign tmo_en = (state_q == ST_LEN) || (state_q == ST_HI) ||
                  (state_q == ST_LO)  || (state_q == ST_CHK);

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept),
    .en_i      (tmo_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wc_d        = wc_q;
    hold_d      = hold_q;
    done_d      = done_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: if (accept && bus.in_data == HEADER) state_d = ST_LEN;
      ST_LEN: begin
        if (accept && len_ok) begin
          rem_d   = bus.in_data;
          sum_d   = bus.in_data;
          wc_d    = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          state_d = ST_HI;
        end else if (accept) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          hold_d  = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_HI: begin
        if (accept) begin
          hi_d    = bus.in_data;
          sum_d   = sum_q + bus.in_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          sum_d       = sum_q + bus.in_data;
          mem_we_d    = 1'b1;
          mem_addr_d  = {wc_q[ADDR_W-2:0], 1'b0};
          mem_wdata_d = {hi_q, bus.in_data};
          wc_d        = wc_q + ADDR_W'(1);
          rem_d       = rem_q - 8'd1;
          state_d     = (rem_q == 8'd1) ? ST_CHK : ST_HI;
        end
      end
      ST_CHK: begin
        if (accept && bus.in_data == sum_q) begin
          done_d  = 1'b1;
          hold_d  = 1'b0;
          state_d = ST_DONE;
        end else if (accept) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          hold_d  = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        if (accept && bus.in_data == HEADER) begin
          hold_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_LEN;
        end
      end
      ST_ERR: begin
        if (accept && bus.in_data == HEADER) begin
          err_d   = 1'b0;
          state_d = ST_LEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // expired only asserts inside a frame; an accepted byte in that cycle wins
    if (expired && !accept) begin
      err_d   = 1'b1;
      done_d  = 1'b0;
      hold_d  = 1'b1;
      state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      arm_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      hi_q        <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wc_q        <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= 1'b1;
      in_ready_q  <= arm_q;
      hi_q        <= hi_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wc_q        <= wc_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign error         = err_q;
  assign word_count    = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: memory writes are checked against a
// queue of expected {addr, data} pushed as payload bytes are driven.
module tb_program_loader;
  import chip8_pkg::*;

  localparam int ADDR_W = 8;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();
  logic              cpu_hold, done, error;
  logic [ADDR_W-1:0] word_count;

  program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;

  always @(posedge clk) begin
    #1;
    if (bus.mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL mem_write unexpected: got addr=%0h data=%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== mon_exp) begin
          miscompares++;
          $display("FAIL mem_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   bus.mem_addr, bus.mem_wdata, mon_exp[23:16], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_wait: got in_ready=%b after %0d cycles, expected 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n, input logic [15:0] w[$], input logic [7:0] chk_flip);
    logic [7:0] s;
    s = n;
    send_byte(HEADER_BYTE);
    send_byte(n);
    foreach (w[i]) begin
      send_byte(w[i][15:8]);
      s = s + w[i][15:8];
      exp_q.push_back({ADDR_W'(2 * i), w[i]});
      send_byte(w[i][7:0]);
      s = s + w[i][7:0];
    end
    send_byte(s ^ chk_flip);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got rdy=%b we=%b addr=%0h data=%0h, expected all 0",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    vectors++;
    if ({cpu_hold, done, error, word_count} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_status: got hold=%b done=%b err=%b wc=%0d, expected 1 0 0 0",
               cpu_hold, done, error, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_first_cycle: got %b expected 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_second_cycle: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_good_load();
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_q.push_back({8'h00, 16'h1234});
    send_byte(8'h12);
    send_byte(8'h34);
    exp_q.push_back({8'h02, 16'h00E0});
    send_byte(8'h00);
    send_byte(8'hE0);
    vectors++;
    if ({bus.mem_we, bus.mem_addr, cpu_hold} !== {1'b1, 8'h02, 1'b1}) begin
      miscompares++;
      $display("FAIL last_write_timing: got we=%b addr=%0h hold=%b, expected 1 02 1",
               bus.mem_we, bus.mem_addr, cpu_hold);
    end
    send_byte(8'h28);
    vectors++;
    if ({cpu_hold, done, error, word_count} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
      miscompares++;
      $display("FAIL good_load_status: got hold=%b done=%b err=%b wc=%0d, expected 0 1 0 2",
               cpu_hold, done, error, word_count);
    end
  endtask

  task automatic test_bad_chk();
    logic [15:0] w[$];
    w = '{16'h1234, 16'h00E0};
    send_frame(8'h02, w, 8'h01);
    vectors++;
    if ({cpu_hold, done, error, word_count} !== {1'b1, 1'b0, 1'b1, 8'd2}) begin
      miscompares++;
      $display("FAIL bad_chk_status: got hold=%b done=%b err=%b wc=%0d, expected 1 0 1 2",
               cpu_hold, done, error, word_count);
    end
  endtask

  task automatic test_bad_len();
    logic [7:0] lens[2];
    lens = '{8'h00, 8'h81};
    foreach (lens[i]) begin
      send_byte(8'hA5);
      vectors++;
      if (error !== 1'b0) begin
        miscompares++;
        $display("FAIL err_clear_on_header: got error=%b expected 0", error);
      end
      send_byte(lens[i]);
      vectors++;
      if ({error, cpu_hold} !== 2'b11) begin
        miscompares++;
        $display("FAIL bad_len_%0h: got err=%b hold=%b, expected 1 1", lens[i], error, cpu_hold);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bad_len_writes: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_done_restart();
    logic [15:0] w[$];
    logic [7:0]  junk[2];
    w    = '{16'h6A05};
    junk = '{8'h7F, 8'hFF};
    send_frame(8'h01, w, 8'h00);
    foreach (junk[i]) begin
      send_byte(junk[i]);
      vectors++;
      if ({cpu_hold, done} !== 2'b01) begin
        miscompares++;
        $display("FAIL done_ignore_%0h: got hold=%b done=%b, expected 0 1", junk[i], cpu_hold, done);
      end
    end
    send_byte(8'hA5);
    vectors++;
    if ({cpu_hold, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL done_restart: got hold=%b done=%b, expected 1 0", cpu_hold, done);
    end
    send_byte(8'h01);
    exp_q.push_back({8'h00, 16'h00E0});
    send_byte(8'h00);
    send_byte(8'hE0);
    send_byte(8'hE1);
    vectors++;
    if ({cpu_hold, done, word_count} !== {1'b0, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL restart_load: got hold=%b done=%b wc=%0d, expected 0 1 1", cpu_hold, done, word_count);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TMO - 1) @(posedge clk);
    #1;
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got error=%b after %0d idle cycles, expected 0", error, TMO - 1);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({error, cpu_hold, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL timeout_hit: got err=%b hold=%b done=%b, expected 1 1 0", error, cpu_hold, done);
    end
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TMO - 1) @(posedge clk);
    exp_q.push_back({8'h00, 16'h1234});
    send_byte(8'h34);
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_byte_wins: got error=%b, expected 0", error);
    end
    send_byte(8'h47);
    vectors++;
    if ({done, error, word_count} !== {1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL timeout_recover: got done=%b err=%b wc=%0d, expected 1 0 1", done, error, word_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[$];
    for (int f = 0; f < 2; f++) begin
      w = {};
      w.push_back(16'hA5A5);
      for (int i = 0; i < 3 + f; i++) w.push_back(16'($urandom));
      send_frame(8'(w.size()), w, 8'h00);
      vectors++;
      if ({done, cpu_hold, word_count} !== {1'b1, 1'b0, 8'(w.size())}) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: got done=%b hold=%b wc=%0d, expected 1 0 %0d",
                 f, done, cpu_hold, word_count, w.size());
      end
    end
  endtask

  task automatic test_max_len();
    logic [15:0] w[$];
    w = {};
    for (int i = 0; i < 128; i++) w.push_back(16'($urandom));
    send_frame(8'h80, w, 8'h00);
    vectors++;
    if ({done, error, word_count} !== {1'b1, 1'b0, 8'h80}) begin
      miscompares++;
      $display("FAIL max_len: got done=%b err=%b wc=%0d, expected 1 0 128", done, error, word_count);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w[$];
    send_byte(8'hA5);
    send_byte(8'h03);
    exp_q.push_back({8'h00, 16'h1122});
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error, word_count}
        !== {26'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL midframe_reset: got rdy=%b we=%b addr=%0h data=%0h hold=%b done=%b err=%b wc=%0d, expected 0 0 0 0 1 0 0 0",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    w = '{16'h00E0, 16'h1A2B};
    send_frame(8'h02, w, 8'h00);
    vectors++;
    if ({done, cpu_hold, word_count} !== {1'b1, 1'b0, 8'd2}) begin
      miscompares++;
      $display("FAIL after_reset_load: got done=%b hold=%b wc=%0d, expected 1 0 2", done, cpu_hold, word_count);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_good_load();
    test_bad_chk();
    test_bad_len();
    test_done_restart();
    test_timeout();
    test_back_to_back();
    test_max_len();
    test_reset_midframe();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
